// File: rtl/barrel_shift_sequencer.sv
// Registered front-end for barrel_shifter16: accepts shift commands, runs one or more
// passes through the external combinational shifter, and returns the final word.
module barrel_shift_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_data,
    input  logic [3:0]  cmd_amt,
    input  logic        cmd_dir,
    input  logic [1:0]  cmd_rep,
    output logic [15:0] sh_i,
    output logic [3:0]  sh_s,
    output logic        sh_sel,
    input  logic [15:0] sh_o,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_data,
    output logic        busy,
    output logic [7:0]  op_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state_reg;
    state_t      state_next;
    logic [15:0] work_reg;
    logic [15:0] sh_i_reg;
    logic [3:0]  amt_reg;
    logic        dir_reg;
    logic [1:0]  pass_reg;
    logic [7:0]  op_count_reg;

    logic        accept;
    logic        pass_step;
    logic        last_pass;
    logic        res_take;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Handshake outputs decode from state only, so cmd_*/res_ready never reach an output.
    always_comb begin
        state_next = state_reg;
        cmd_ready  = 1'b0;
        res_valid  = 1'b0;
        busy       = 1'b1;
        accept     = 1'b0;
        pass_step  = 1'b0;
        last_pass  = 1'b0;
        res_take   = 1'b0;
        case (state_reg)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    accept     = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                pass_step = 1'b1;
                if (pass_reg == 2'd0) begin
                    last_pass  = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    res_take   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            work_reg     <= 16'h0000;
            sh_i_reg     <= 16'h0000;
            amt_reg      <= 4'h0;
            dir_reg      <= 1'b0;
            pass_reg     <= 2'd0;
            op_count_reg <= 8'h00;
        end else begin
            if (accept) begin
                work_reg <= cmd_data;
                sh_i_reg <= cmd_data;
                amt_reg  <= cmd_amt;
                dir_reg  <= cmd_dir;
                pass_reg <= cmd_rep;
            end
            if (pass_step) begin
                work_reg <= sh_o;
                // Shifter input stays on the last pass operand once the passes are spent.
                if (!last_pass) begin
                    sh_i_reg <= sh_o;
                    pass_reg <= pass_reg - 2'd1;
                end
            end
            if (res_take) begin
                op_count_reg <= op_count_reg + 8'd1;
            end
        end
    end

    assign sh_i     = sh_i_reg;
    assign sh_s     = amt_reg;
    assign sh_sel   = dir_reg;
    assign res_data = work_reg;
    assign op_count = op_count_reg;

endmodule

// File: tb/tb_barrel_shift_sequencer.sv
// Directed bench for barrel_shift_sequencer; a behavioural barrel_shifter16 closes the loop.
module tb_barrel_shift_sequencer;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_data;
    logic [3:0]  cmd_amt;
    logic        cmd_dir;
    logic [1:0]  cmd_rep;
    logic [15:0] sh_i;
    logic [3:0]  sh_s;
    logic        sh_sel;
    logic [15:0] sh_o;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic        busy;
    logic [7:0]  op_count;

    int tests_run;
    int tests_failed;

    barrel_shift_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_data  (cmd_data),
        .cmd_amt   (cmd_amt),
        .cmd_dir   (cmd_dir),
        .cmd_rep   (cmd_rep),
        .sh_i      (sh_i),
        .sh_s      (sh_s),
        .sh_sel    (sh_sel),
        .sh_o      (sh_o),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .busy      (busy),
        .op_count  (op_count)
    );

    // Behavioural stand-in for the downstream combinational shifter.
    assign sh_o = sh_sel ? (sh_i << sh_s) : (sh_i >> sh_s);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Offer a command from a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input logic [15:0] d, input logic [3:0] a, input logic dir,
                         input logic [1:0] r);
        int ok;
        cmd_data  = d;
        cmd_amt   = a;
        cmd_dir   = dir;
        cmd_rep   = r;
        cmd_valid = 1'b1;
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            if (cmd_ready) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        tests_run++;
        if (ok == 0) begin
            tests_failed++;
            $display("FAIL issue_timeout: cmd_ready=%b required 1 within 20 cycles", cmd_ready);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Wait for res_valid; n counts negedges after the accept negedge. Optionally take it.
    task automatic wait_result(input logic take, output logic [15:0] d, output int n);
        n = 0;
        while (!res_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (!res_valid) begin
            tests_failed++;
            $display("FAIL result_timeout: res_valid=%b required 1 within 20 cycles", res_valid);
        end
        d = res_data;
        $display("[TB] result 0x%04h after %0d cycles, op_count %0d", d, n, op_count);
        if (take) begin
            res_ready = 1'b1;
            @(negedge clk);
            res_ready = 1'b0;
        end
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        repeat (cycles) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset_initial;
        do_reset(3);
        tests_run++;
        if ({res_valid, busy, cmd_ready} !== 3'b001) begin
            tests_failed++;
            $display("FAIL reset_flags: valid/busy/ready=%b required 001", {res_valid, busy, cmd_ready});
        end
        tests_run++;
        if (op_count !== 8'd0 || res_data !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_regs: op_count=%0d res_data=0x%04h required 0/0x0000", op_count, res_data);
        end
        tests_run++;
        if (sh_i !== 16'h0000 || sh_s !== 4'h0 || sh_sel !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_sh: sh_i=0x%04h sh_s=%0d sh_sel=%b required 0", sh_i, sh_s, sh_sel);
        end
    endtask

    task automatic test_single_pass;
        logic [15:0] d;
        int n;
        issue(16'hA861, 4'd8, 1'b1, 2'd0);
        tests_run++;
        if (sh_i !== 16'hA861 || sh_s !== 4'd8 || sh_sel !== 1'b1 || busy !== 1'b1 || cmd_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_drive: sh_i=0x%04h sh_s=%0d sel=%b busy=%b ready=%b required 0xa861/8/1/1/0",
                     sh_i, sh_s, sh_sel, busy, cmd_ready);
        end
        wait_result(1'b1, d, n);
        tests_run++;
        if (d !== 16'h6100 || n != 1) begin
            tests_failed++;
            $display("FAIL single_result: data=0x%04h lat=%0d required 0x6100 lat 1", d, n);
        end
        tests_run++;
        if (op_count !== 8'd1 || cmd_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL single_count: op_count=%0d ready=%b required 1/1", op_count, cmd_ready);
        end
    endtask

    task automatic test_reset_mid_op;
        issue(16'h00FF, 4'd1, 1'b1, 2'd3);
        do_reset(2);
        tests_run++;
        if ({res_valid, busy, cmd_ready} !== 3'b001 || op_count !== 8'd0) begin
            tests_failed++;
            $display("FAIL reset_mid: valid/busy/ready=%b op_count=%0d required 001/0",
                     {res_valid, busy, cmd_ready}, op_count);
        end
        repeat (6) @(negedge clk);
        tests_run++;
        if (res_valid !== 1'b0 || op_count !== 8'd0) begin
            tests_failed++;
            $display("FAIL reset_abandon: res_valid=%b op_count=%0d required 0/0", res_valid, op_count);
        end
    endtask

    task automatic test_single_vectors;
        logic [15:0] vd [3] = '{16'hFFFF, 16'h0001, 16'h0001};
        logic [3:0]  va [3] = '{4'd8, 4'd15, 4'd15};
        logic        vr [3] = '{1'b0, 1'b0, 1'b1};
        logic [15:0] ve [3] = '{16'h00FF, 16'h0000, 16'h8000};
        logic [15:0] d;
        int n;
        for (int i = 0; i < 3; i++) begin
            issue(vd[i], va[i], vr[i], 2'd0);
            wait_result(1'b1, d, n);
            tests_run++;
            if (d !== ve[i] || n != 1) begin
                tests_failed++;
                $display("FAIL shift_vec%0d: data=0x%04h lat=%0d required 0x%04h lat 1", i, d, n, ve[i]);
            end
        end
    endtask

    task automatic test_repeat;
        logic [15:0] vd [3] = '{16'h0001, 16'hCE39, 16'h8421};
        logic [3:0]  va [3] = '{4'd4, 4'd6, 4'd0};
        logic        vr [3] = '{1'b1, 1'b1, 1'b0};
        logic [1:0]  vp [3] = '{2'd2, 2'd3, 2'd3};
        logic [15:0] ve [3] = '{16'h1000, 16'h0000, 16'h8421};
        logic [15:0] d;
        int n;
        for (int i = 0; i < 3; i++) begin
            issue(vd[i], va[i], vr[i], vp[i]);
            wait_result(1'b1, d, n);
            tests_run++;
            if (d !== ve[i] || n != int'(vp[i]) + 1) begin
                tests_failed++;
                $display("FAIL repeat_vec%0d: data=0x%04h lat=%0d required 0x%04h lat %0d",
                         i, d, n, ve[i], int'(vp[i]) + 1);
            end
        end
    endtask

    task automatic test_backpressure;
        logic [15:0] d;
        logic [7:0]  cnt;
        int n;
        int bad;
        issue(16'h00F0, 4'd4, 1'b1, 2'd0);
        wait_result(1'b0, d, n);
        cnt = op_count;
        cmd_data  = 16'h1234;
        cmd_amt   = 4'd4;
        cmd_dir   = 1'b0;
        cmd_rep   = 2'd1;
        cmd_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (res_data !== 16'h0F00 || cmd_ready !== 1'b0 || res_valid !== 1'b1 || op_count !== cnt)
                bad++;
            @(negedge clk);
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL stall_hold: %0d bad cycles, res_data=0x%04h ready=%b required 0x0f00/0", bad, res_data, cmd_ready);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        tests_run++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || op_count !== cnt + 8'd1) begin
            tests_failed++;
            $display("FAIL stall_release: ready=%b busy=%b op_count=%0d required 1/0/%0d",
                     cmd_ready, busy, op_count, cnt + 8'd1);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        tests_run++;
        if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL second_accept: busy=%b ready=%b required 1/0", busy, cmd_ready);
        end
        wait_result(1'b1, d, n);
        tests_run++;
        if (d !== 16'h0012 || n != 2) begin
            tests_failed++;
            $display("FAIL second_result: data=0x%04h lat=%0d required 0x0012 lat 2", d, n);
        end
    endtask

    task automatic test_wrap;
        logic [15:0] d;
        logic [15:0] v;
        int n;
        do_reset(1);
        for (int i = 0; i < 256; i++) begin
            v = 16'(i * 257) ^ 16'h5A3C;
            issue(v, 4'd0, v[0], v[2:1]);
            wait_result(1'b1, d, n);
            tests_run++;
            if (d !== v || op_count !== 8'(i + 1)) begin
                tests_failed++;
                $display("FAIL wrap_%0d: data=0x%04h op_count=%0d required 0x%04h/%0d",
                         i, d, op_count, v, 8'(i + 1));
            end
        end
        tests_run++;
        if (op_count !== 8'd0) begin
            tests_failed++;
            $display("FAIL wrap_count: op_count=%0d required 0", op_count);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        cmd_valid    = 1'b0;
        cmd_data     = 16'h0000;
        cmd_amt      = 4'h0;
        cmd_dir      = 1'b0;
        cmd_rep      = 2'd0;
        res_ready    = 1'b0;
        @(negedge clk);
        test_reset_initial;
        test_single_pass;
        test_reset_mid_op;
        test_single_vectors;
        test_repeat;
        test_backpressure;
        test_wrap;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/barrel_shift_sequencer.md
# barrel_shift_sequencer

- Registered front-end for `barrel_shifter16`; sits directly upstream of it and owns its operand, amount and direction inputs.
- Accepts shift commands over a valid/ready handshake and drives the combinational shifter.
- Captures the shifter output each cycle and can feed the result back through the shifter for repeated passes.
- Returns the final word over a second valid/ready handshake.

## Interface
Parameters:
- none (datapath fixed at 16 bits, amount at 4 bits, to match `barrel_shifter16`)

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  reset; synchronous, active-low
- cmd_valid  input  1  command present
- cmd_ready  output  1  sequencer can accept a command
- cmd_data  input  16  operand word
- cmd_amt  input  4  shift amount per pass, 0-15
- cmd_dir  input  1  direction: 1 = logical left, 0 = logical right; zero-fill either way
- cmd_rep  input  2  extra passes; total passes = cmd_rep+1 (1-4)
- sh_i  output  16  to shifter `i`
- sh_s  output  4  to shifter {s3,s2,s1,s0}; sh_s[0] drives s0
- sh_sel  output  1  to shifter `shift_sel`; equals latched cmd_dir
- sh_o  input  16  from shifter `o`; combinational function of sh_i/sh_s/sh_sel
- res_valid  output  1  result present
- res_ready  input  1  consumer accepts result
- res_data  output  16  final shifted word
- busy  output  1  high in any state other than IDLE
- op_count  output  8  completed results; wraps 255 -> 0

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid & cmd_ready: latch cmd_data into work, latch amt/dir, and set pass counter = cmd_rep. Go to SHIFT.
- SHIFT:
  - sh_i = work; sh_s = amt; sh_sel = dir.
  - Each cycle: work <= sh_o.
  - If pass counter == 0, go to DONE; otherwise decrement it and stay in SHIFT.
- DONE:
  - res_valid = 1; res_data = work, held stable until res_valid & res_ready.
  - On that handshake: op_count <= op_count+1 (mod 256), then go to IDLE.
- cmd_ready is 0 in SHIFT and DONE. A command offered then is not consumed and must be held by the producer.
- cmd_amt = 0 is legal: the word passes through unchanged, but all passes are still spent.
- Repeated passes compose. The total shift is min(16, amt×(rep+1)), so bits shifted out are lost.
- sh_* outputs hold their last values in IDLE and DONE; they are don't-care there.

## Timing
- Reset, on a clk edge with rst_n = 0: state = IDLE; work, amt, dir, pass counter, sh_i, sh_s, sh_sel, res_data and op_count = 0; res_valid = 0; busy = 0; cmd_ready = 1 after reset.
- Reset mid-operation (SHIFT or DONE) abandons the command. No result is produced and op_count is not incremented.
- Latency: with accept at edge k, res_valid rises after edge k+cmd_rep+1.
- Minimum command spacing is cmd_rep+3 cycles: accept, passes, one DONE cycle with res_ready = 1, then the return to IDLE.
- res_ready held low stalls in DONE indefinitely; res_data and op_count stay stable.
- No command can be accepted in the cycle a result handshake completes; cmd_ready rises the following cycle.
- All outputs are registered or decoded from the state alone. There is no combinational path from cmd_* or res_ready to any output.

## Test plan
- Reset: hold rst_n = 0 for 2 cycles while in SHIFT -> res_valid = 0, op_count = 0, cmd_ready = 1, busy = 0 after release.
- Single pass: data 0xA861, amt 8, dir 1, rep 0, res_ready = 1 -> res_data = 0x6100 one cycle after accept; op_count = 1.
- Right shift, all ones: 0xFFFF, amt 8, dir 0 -> 0x00FF. Then 0x0001, amt 15, dir 0 -> 0x0000. Then 0x0001, amt 15, dir 1 -> 0x8000.
- Repeat: 0x0001, amt 4, dir 1, rep 2 -> 0x1000 three cycles after accept. Then 0xCE39, amt 6, dir 1, rep 3 -> 0x0000 (total shift of 24 clamps to 16, so every bit is lost).
- Backpressure: hold res_ready = 0 for 5 cycles with cmd_valid high -> res_data stable, cmd_ready = 0, second command not consumed. Then res_ready = 1 -> second command accepted 1 cycle later.
- Wrap: complete 256 commands (amt 0) -> op_count reads 0 and every res_data equals its cmd_data.
